instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have port: clk_i  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_i  in  1  reset, asynchronous and active-high.
REQ-003 SHALL have port: pc_i  in  32  current fetch address from the program counter.
REQ-004 SHALL have port: pc_Write_o  out  1  PC hold control to the program counter: 1 = hold PC, 0 = load next PC.
REQ-005 SHALL have port: flush_i  in  1  branch/jump taken; discard all fetched and in-flight instructions.
REQ-006 SHALL have port: imem_req_o  out  1  instruction memory request, level, registered.
REQ-007 SHALL have port: imem_addr_o  out  32  request address, registered, stable while imem_req_o=1.
REQ-008 SHALL have port: imem_ack_i  in  1  memory response strobe, one cycle per request, any latency >=1.
REQ-009 SHALL have port: imem_data_i  in  32  instruction word, valid when imem_ack_i=1.
REQ-010 SHALL have ports: instr_valid_o out 1, instr_o out 32, instr_pc_o out 32, instr_ready_i in 1: decode-side valid/ready.
REQ-011 SHALL have port: count_o  out  3  queue occupancy, 0..4.

Function
REQ-012 SHALL hold a 4-entry FIFO of {pc, instruction} pairs; head drives instr_pc_o/instr_o; instr_valid_o = (count != 0).
REQ-013 SHALL implement FSM IDLE, WAIT, DROP; imem_req_o = 1 exactly in WAIT and DROP.
REQ-014 IDLE: if count < 4 and flush_i=0, SHALL register imem_addr_o <= pc_i and go WAIT; else stay IDLE.
REQ-015 WAIT, imem_ack_i=1, flush_i=0: SHALL push {imem_addr_o, imem_data_i}, drive pc_Write_o=0 that cycle, go IDLE.
REQ-016 WAIT, flush_i=1, imem_ack_i=0: SHALL go DROP; WAIT, flush_i=1, imem_ack_i=1: SHALL discard data, go IDLE.
REQ-017 DROP: SHALL keep imem_req_o=1, address unchanged; on imem_ack_i=1 discard data, go IDLE; flush_i in DROP stays DROP.
REQ-018 pc_Write_o SHALL be 0 when flush_i=1 (PC loads branch target) or per REQ-015; 1 in all other cycles.
REQ-019 Pop SHALL occur when instr_valid_o=1 and instr_ready_i=1; simultaneous push and pop keeps count unchanged.
REQ-020 flush_i=1 SHALL clear count and pointers next cycle, overriding any same-cycle push or pop.
REQ-021 Response-to-output latency SHALL be 1 cycle (ack at edge N, instr_valid_o at N+1); no combinational path imem_data_i -> instr_o.
REQ-022 Exactly one memory request SHALL be outstanding at a time; pointers wrap modulo 4; count never exceeds 4.
REQ-023 imem_ack_i in IDLE SHALL be ignored.

Reset
REQ-024 While rst_i=1, asynchronously: state IDLE, count 0, pointers 0, imem_req_o 0, imem_addr_o 0, instr_valid_o 0, pc_Write_o 1.
REQ-025 Reset during WAIT/DROP SHALL abandon the in-flight request; a late ack after reset release is ignored per REQ-023.
REQ-026 instr_o, instr_pc_o storage SHALL reset to 0.

Configuration
REQ-027 Macro IFQ_PERF_EN defined: SHALL add output stall_cnt_o (32) counting cycles with pc_Write_o=1 and state != IDLE, reset 0, wraps at 2^32.
REQ-028 IFQ_PERF_EN undefined: stall_cnt_o and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset, pc_i=0x0, ack latency 1, ready=1 -> imem_addr_o=0x0, instr_pc_o=0x0 valid one cycle after ack, pc_Write_o=0 only in ack cycle.
REQ-030 ready=0, 5 fetches from pc 0x0/0x4/0x8/0xC/0x10 -> count_o=4, no request for 0x10 until one pop, pc_Write_o=1 meanwhile.
REQ-031 Ack latency 3, flush_i pulse in first WAIT cycle -> DROP, data at ack discarded, count_o stays 0, pc_Write_o=0 in flush cycle.
REQ-032 count_o=4, flush_i=1 with instr_ready_i=1 same cycle -> count_o=0 next cycle, instr_valid_o=0.
REQ-033 count_o=2, push and pop same cycle -> count_o=2, head advances to next pc, FIFO order preserved across wrap.
REQ-034 rst_i asserted mid-WAIT asynchronously -> imem_req_o=0 before next edge; IFQ_PERF_EN build: stall_cnt_o=0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_queue
//  Description : Instruction fetch front end. Issues one instruction-memory
//                request at a time, buffers {pc, instruction} pairs in a
//                4-entry FIFO and presents them to decode via valid/ready.
//                A flush (taken branch/jump) empties the FIFO and discards
//                the response of any request still in flight.
//                Optional macro IFQ_PERF_EN adds the stall_cnt_o counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    output logic        pc_Write_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic [2:0]  count_o
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int unsigned DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q;

    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;

    logic        push;
    logic        pop;

    // Fetch FSM: decides when to issue, and whether a returning word is kept
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Only issue when a slot is guaranteed free for the response
                if ((count_q < 3'(DEPTH)) && !flush_i) begin
                    state_d = S_WAIT;
                    addr_d  = pc_i;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = imem_ack_i ? S_IDLE : S_DROP;
                end else if (imem_ack_i) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                // Stale request: wait out its response, then throw it away
                if (imem_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy update; flush wins over push and pop
    always_comb begin
        pop = (count_q != 3'd0) && instr_ready_i && !flush_i;
        if (flush_i) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            wr_ptr_d = wr_ptr_q + 2'(push);
            rd_ptr_d = rd_ptr_q + 2'(pop);
            count_d  = count_q + 3'(push) - 3'(pop);
        end
    end

    // Control registers: FSM state, request address, request strobe, pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            req_q    <= 1'b0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            req_q    <= (state_d != S_IDLE);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage: captures the response word together with its address
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]    <= 32'd0;
                instr_mem_q[i] <= 32'd0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]    <= addr_q;
            instr_mem_q[wr_ptr_q] <= imem_data_i;
        end
    end

`ifdef IFQ_PERF_EN
    logic [31:0] stall_cnt_q;

    // Cycles where the PC is held while a fetch is outstanding
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
        end else if (pc_Write_o && (state_q != S_IDLE)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    // PC advances on a kept response or on a flush (branch target load);
    // reset forces hold regardless of the flush input
    assign pc_Write_o    = rst_i | ~(flush_i | push);
    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = (count_q != 3'd0);
    assign instr_o       = instr_mem_q[rd_ptr_q];
    assign instr_pc_o    = pc_mem_q[rd_ptr_q];
    assign count_o       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_queue
//  Description : Randomized self-checking bench for instr_fetch_queue with a
//                queue-based reference model and a random-latency memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_write;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  count;
`ifdef IFQ_PERF_EN
    logic [31:0] stall_cnt;
`endif

    instr_fetch_queue u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_i          (pc),
        .pc_Write_o    (pc_write),
        .flush_i       (flush),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (instr_ready),
        .count_o       (count)
`ifdef IFQ_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: buffered fetches in order, plus the one outstanding request
    logic [63:0] q[$];
    bit          busy;
    bit          dropping;
    logic [31:0] req_addr;
    int          lat_cnt;
    int          lat_tgt;
    logic [31:0] stall_exp;
    bit          exp_pcw;
    int          full_seen;

    task automatic model_reset();
        q.delete();
        busy      = 1'b0;
        dropping  = 1'b0;
        req_addr  = 32'd0;
        lat_cnt   = 0;
        lat_tgt   = 1;
        stall_exp = 32'd0;
    endtask

    task automatic check_outputs();
        check_eq("valid", 64'(instr_valid), 64'(q.size() != 0));
        check_eq("count", 64'(count), 64'(q.size()));
        check_eq("req", 64'(imem_req), 64'(busy));
        check_eq("pc_write", 64'(pc_write), 64'(exp_pcw));
        if (busy) check_eq("addr", 64'(imem_addr), 64'(req_addr));
        if (q.size() != 0) begin
            check_eq("head_pc", 64'(instr_pc), 64'(q[0][63:32]));
            check_eq("head_instr", 64'(instr), 64'(q[0][31:0]));
        end
`ifdef IFQ_PERF_EN
        check_eq("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
`endif
    endtask

    // Apply the cycle's inputs to the model at the rising edge
    task automatic model_step();
        int  old_size;
        bit  push_e;
        bit  pop_e;
        old_size = q.size();
        push_e   = busy && !dropping && imem_ack && !flush;
        pop_e    = (old_size != 0) && instr_ready && !flush;
        if (exp_pcw && busy) stall_exp = stall_exp + 32'd1;
        if (flush) begin
            q.delete();
        end else begin
            if (pop_e)  void'(q.pop_front());
            if (push_e) q.push_back({req_addr, imem_data});
        end
        if (busy) begin
            lat_cnt++;
            if (imem_ack) begin
                busy     = 1'b0;
                dropping = 1'b0;
            end else if (flush) begin
                dropping = 1'b1;
            end
        end else if (old_size < 4 && !flush) begin
            busy     = 1'b1;
            dropping = 1'b0;
            req_addr = pc;
            lat_cnt  = 0;
            lat_tgt  = int'($urandom_range(1, 4));
        end
        if (q.size() == 4) full_seen++;
    endtask

    initial begin
        int ready_pct;
        bit did_rst;
        rst         = 1'b1;
        pc          = 32'd0;
        flush       = 1'b0;
        imem_ack    = 1'b0;
        imem_data   = 32'd0;
        instr_ready = 1'b0;
        did_rst     = 1'b0;
        full_seen   = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp_pcw = 1'b1;
        check_eq("rst_req", 64'(imem_req), 64'd0);
        check_eq("rst_addr", 64'(imem_addr), 64'd0);
        check_eq("rst_valid", 64'(instr_valid), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_pcw", 64'(pc_write), 64'd1);
        check_eq("rst_instr", 64'(instr), 64'd0);
        check_eq("rst_ipc", 64'(instr_pc), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            // Phases alternate decode back-pressure to reach full and empty
            case ((i / 150) % 4)
                0: ready_pct = 90;
                1: ready_pct = 0;
                2: ready_pct = 40;
                default: ready_pct = 10;
            endcase

            if (i >= 1200 && !did_rst && busy) begin
                // Asynchronous reset while a request is in flight
                did_rst  = 1'b1;
                flush    = 1'b0;
                imem_ack = 1'b0;
                #1 rst = 1'b1;
                #1;
                check_eq("arst_req", 64'(imem_req), 64'd0);
                check_eq("arst_count", 64'(count), 64'd0);
                check_eq("arst_valid", 64'(instr_valid), 64'd0);
                check_eq("arst_pcw", 64'(pc_write), 64'd1);
`ifdef IFQ_PERF_EN
                check_eq("arst_stall", 64'(stall_cnt), 64'd0);
`endif
                @(posedge clk);
                #1 rst = 1'b0;
                model_reset();
                // A late response arriving in IDLE must be ignored
                imem_ack  = 1'b1;
                imem_data = $urandom;
                pc        = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                flush       = 1'b0;
                instr_ready = 1'b1;
                exp_pcw   = 1'b1;
                #2 check_outputs();
                @(posedge clk);
                model_step();
                #1;
                continue;
            end

            flush       = ($urandom_range(0, 15) == 0);
            instr_ready = ($urandom_range(0, 99) < ready_pct);
            pc          = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            imem_data   = $urandom;
            if (busy) imem_ack = (lat_cnt + 1 >= lat_tgt);
            else      imem_ack = ($urandom_range(0, 7) == 0);
            exp_pcw = !(flush || (busy && !dropping && imem_ack));
            #2 check_outputs();
            @(posedge clk);
            model_step();
            #1;
        end

        check_eq("full_reached", 64'(full_seen != 0), 64'd1);
        check_eq("async_reset_done", 64'(did_rst), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
